nf10_10g_tx_arbiter: RTL and testbench

Packet-granular round-robin scheduler that shares the single 256-bit AXI4-Stream transmit input of one 10G XAUI interface among `C_NUM_QUEUES` output queues. It sits between the output-queue stage and the 10G interface `s_axis_*` port, on `axi_aclk`. It never interleaves beats of different packets and never alters data, strobe or tuser.

---
 rtl/nf10_axis_pkg.sv | 15 +
 rtl/nf10_rr_pick.sv | 28 ++
 rtl/nf10_10g_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_nf10_10g_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nf10_axis_pkg.sv
// Shared AXI4-Stream width constants and arbiter state encoding for the NetFPGA-10G
// transmit path.
package nf10_axis_pkg;

   localparam int unsigned AXIS_DATA_W  = 256;
   localparam int unsigned AXIS_STRB_W  = AXIS_DATA_W / 8;
   localparam int unsigned AXIS_TUSER_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      PKT  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/nf10_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from last+1,
// wrapping modulo the queue count.
module nf10_rr_pick #(
   parameter  int unsigned C_NUM_QUEUES = 4,
   localparam int unsigned IW           = $clog2(C_NUM_QUEUES)
) (
   input  logic [C_NUM_QUEUES-1:0] req,
   input  logic [IW-1:0]           last,
   output logic [C_NUM_QUEUES-1:0] winner_c,
   output logic                    found_c
);

   int unsigned idx;

   always_comb begin
      winner_c = '0;
      found_c  = 1'b0;
      idx      = 0;
      for (int unsigned i = 1; i <= C_NUM_QUEUES; i++) begin
         idx = (32'(last) + i) % C_NUM_QUEUES;
         if (!found_c && req[IW'(idx)]) begin
            winner_c[IW'(idx)] = 1'b1;
            found_c            = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nf10_10g_tx_arbiter.sv
// Packet-granular round-robin scheduler sharing one 10G AXIS transmit port among
// C_NUM_QUEUES output queues; beats of different packets are never interleaved.
module nf10_10g_tx_arbiter
   import nf10_axis_pkg::*;
#(
   parameter int unsigned C_NUM_QUEUES       = 4,
   parameter int unsigned C_AXIS_DATA_WIDTH  = AXIS_DATA_W,
   parameter int unsigned C_AXIS_TUSER_WIDTH = AXIS_TUSER_W
) (
   input  logic                                           axi_aclk,
   input  logic                                           axi_resetn,
   input  logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic [C_NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tstrb,
   input  logic [C_NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic [C_NUM_QUEUES-1:0]                        s_axis_tvalid,
   input  logic [C_NUM_QUEUES-1:0]                        s_axis_tlast,
   output logic [C_NUM_QUEUES-1:0]                        s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]                   m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]                 m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]                  m_axis_tuser,
   output logic                                           m_axis_tvalid,
   output logic                                           m_axis_tlast,
   input  logic                                           m_axis_tready,
   input  logic [C_NUM_QUEUES-1:0]                        queue_en,
   output logic [C_NUM_QUEUES-1:0]                        grant,
   output logic [31:0]                                    pkt_count
);

   localparam int unsigned DW = C_AXIS_DATA_WIDTH;
   localparam int unsigned SW = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned UW = C_AXIS_TUSER_WIDTH;
   localparam int unsigned IW = $clog2(C_NUM_QUEUES);

   arb_state_e              state_q, state_d;
   logic [C_NUM_QUEUES-1:0] grant_d;
   logic [C_NUM_QUEUES-1:0] cand_c;
   logic [C_NUM_QUEUES-1:0] winner_c;
   logic                    found_c;
   logic [IW-1:0]           last_q, last_d;
   logic [IW-1:0]           grant_idx_c;
   logic                    pkt_inc;

   assign cand_c = s_axis_tvalid & queue_en;

   nf10_rr_pick #(
      .C_NUM_QUEUES (C_NUM_QUEUES)
   ) u_pick (
      .req      (cand_c),
      .last     (last_q),
      .winner_c (winner_c),
      .found_c  (found_c)
   );

   // Binary index of the current owner, used to seed the next search.
   always_comb begin
      grant_idx_c = '0;
      for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
         if (grant[i]) grant_idx_c = IW'(i);
      end
   end

   // Owner slice passes straight through in PKT; everything reads zero otherwise.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (state_q == PKT) begin
         s_axis_tready = grant & {C_NUM_QUEUES{m_axis_tready}};
         for (int unsigned i = 0; i < C_NUM_QUEUES; i++) begin
            if (grant[i]) begin
               m_axis_tdata  = s_axis_tdata[i*DW +: DW];
               m_axis_tstrb  = s_axis_tstrb[i*SW +: SW];
               m_axis_tuser  = s_axis_tuser[i*UW +: UW];
               m_axis_tvalid = s_axis_tvalid[i];
               m_axis_tlast  = s_axis_tlast[i];
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant;
      last_d  = last_q;
      pkt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (|cand_c) state_d = ARB;
         end
         ARB: begin
            if (found_c) begin
               grant_d = winner_c;
               state_d = PKT;
            end else begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         PKT: begin
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
               last_d  = grant_idx_c;
               grant_d = '0;
               pkt_inc = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q   <= IDLE;
         grant     <= '0;
         last_q    <= IW'(C_NUM_QUEUES - 1);
         pkt_count <= '0;
      end else begin
         state_q <= state_d;
         grant   <= grant_d;
         last_q  <= last_d;
         if (pkt_inc) pkt_count <= pkt_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_nf10_10g_tx_arbiter.sv
// Directed self-checking bench for nf10_10g_tx_arbiter with 4 queues of 256-bit AXIS.
`timescale 1ns/1ps
module tb_nf10_10g_tx_arbiter;

   localparam int N  = 4;
   localparam int DW = 256;
   localparam int SW = 32;
   localparam int UW = 128;

   logic              clk = 1'b0;
   logic              axi_resetn;
   logic [N*DW-1:0]   s_axis_tdata;
   logic [N*SW-1:0]   s_axis_tstrb;
   logic [N*UW-1:0]   s_axis_tuser;
   logic [N-1:0]      s_axis_tvalid;
   logic [N-1:0]      s_axis_tlast;
   logic [N-1:0]      s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [SW-1:0]     m_axis_tstrb;
   logic [UW-1:0]     m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic [N-1:0]      queue_en;
   logic [N-1:0]      grant;
   logic [31:0]       pkt_count;

   int checks   = 0;
   int failures = 0;

   // Upstream queue sources: packets remaining, length, current beat, packet number.
   int src_cnt  [N];
   int src_len  [N];
   int src_beat [N];
   int src_pkt  [N];

   int pat   [5];
   int pbeat [5];

   always #5 clk = ~clk;

   nf10_10g_tx_arbiter dut (
      .axi_aclk      (clk),
      .axi_resetn    (axi_resetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .queue_en      (queue_en),
      .grant         (grant),
      .pkt_count     (pkt_count)
   );

   function automatic logic [31:0] tag_word(input int q, input int p, input int b);
      return 32'hD000_0000 | (32'(q) << 16) | (32'(p) << 8) | 32'(b);
   endfunction

   function automatic logic [DW-1:0] mk_data(input int q, input int p, input int b);
      logic [31:0] w;
      w = tag_word(q, p, b);
      return {8{w}};
   endfunction

   function automatic logic [UW-1:0] mk_user(input int q, input int p, input int b);
      logic [31:0] w;
      w = tag_word(q, p, b) ^ 32'h0F0F_0000;
      return {4{w}};
   endfunction

   function automatic logic [SW-1:0] mk_strb(input int b);
      return 32'hFFFF_FFFF >> b;
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic drive();
      for (int q = 0; q < N; q++) begin
         s_axis_tvalid[q]             = (src_cnt[q] > 0);
         s_axis_tlast[q]              = (src_beat[q] == src_len[q] - 1);
         s_axis_tdata[q*DW +: DW]     = mk_data(q, src_pkt[q], src_beat[q]);
         s_axis_tuser[q*UW +: UW]     = mk_user(q, src_pkt[q], src_beat[q]);
         s_axis_tstrb[q*SW +: SW]     = mk_strb(src_beat[q]);
      end
   endtask

   task automatic clear_srcs();
      for (int q = 0; q < N; q++) begin
         src_cnt[q]  = 0;
         src_len[q]  = 1;
         src_beat[q] = 0;
         src_pkt[q]  = 0;
      end
   endtask

   // One clock: note handshakes before the edge, advance sources after it.
   task automatic cycle();
      logic [N-1:0] fire;
      fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #2;
      for (int q = 0; q < N; q++) begin
         if (fire[q]) begin
            if (src_beat[q] == src_len[q] - 1) begin
               src_beat[q] = 0;
               src_pkt[q]  = src_pkt[q] + 1;
               src_cnt[q]  = src_cnt[q] - 1;
            end else begin
               src_beat[q] = src_beat[q] + 1;
            end
         end
      end
      drive();
      #1;
   endtask

   task automatic do_reset();
      axi_resetn = 1'b0;
      clear_srcs();
      drive();
      repeat (2) @(posedge clk);
      #3 axi_resetn = 1'b1;
      #1;
   endtask

   // Waits for the grant, then checks every beat of one packet from queue q.
   task automatic expect_pkt(input int q, input int p, input int len, input int exp_wait,
                             input logic [N-1:0] en_after);
      int           waits;
      int           guard;
      logic [N-1:0] oh;
      oh    = '0;
      oh[q] = 1'b1;
      waits = 0;
      while (grant == '0 && waits < 16) begin
         cycle();
         waits++;
      end
      chk("pkt_wait", DW'(waits), DW'(exp_wait));
      chk("pkt_grant", DW'(grant), DW'(oh));
      for (int b = 0; b < len; b++) begin
         guard = 0;
         while (!(m_axis_tvalid && m_axis_tready) && guard < 16) begin
            cycle();
            guard++;
         end
         chk("beat_hs", DW'(m_axis_tvalid & m_axis_tready), DW'(1));
         chk("beat_grant", DW'(grant), DW'(oh));
         chk("beat_tdata", m_axis_tdata, mk_data(q, p, b));
         chk("beat_tuser", DW'(m_axis_tuser), DW'(mk_user(q, p, b)));
         chk("beat_tstrb", DW'(m_axis_tstrb), DW'(mk_strb(b)));
         chk("beat_tlast", DW'(m_axis_tlast), DW'(b == len - 1));
         if (b == 0) queue_en = en_after;
         cycle();
      end
      chk("pkt_release", DW'(grant), DW'(0));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      axi_resetn    = 1'b0;
      m_axis_tready = 1'b1;
      queue_en      = 4'b1111;
      clear_srcs();
      for (int q = 0; q < N; q++) src_cnt[q] = 1;
      drive();
      repeat (2) @(posedge clk);
      #1;
      // Reset state while every queue is requesting.
      chk("rst_grant", DW'(grant), DW'(0));
      chk("rst_pkt_count", DW'(pkt_count), DW'(0));
      chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
      chk("rst_tdata", m_axis_tdata, DW'(0));
      chk("rst_tstrb", DW'(m_axis_tstrb), DW'(0));
      chk("rst_tuser", DW'(m_axis_tuser), DW'(0));
      chk("rst_s_tready", DW'(s_axis_tready), DW'(0));
      clear_srcs();
      drive();
      #2 axi_resetn = 1'b1;
      #1;

      // Single queue 2, 3-beat packet: IDLE->ARB->PKT latency and bit-exact beats.
      src_cnt[2] = 1;
      src_len[2] = 3;
      drive();
      cycle();
      chk("t1_arb_grant", DW'(grant), DW'(0));
      chk("t1_arb_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("t1_arb_tdata", m_axis_tdata, DW'(0));
      for (int b = 0; b < 3; b++) begin
         cycle();
         chk("t1_grant", DW'(grant), DW'(4'b0100));
         chk("t1_tvalid", DW'(m_axis_tvalid), DW'(1));
         chk("t1_tdata", m_axis_tdata, mk_data(2, 0, b));
         chk("t1_tuser", DW'(m_axis_tuser), DW'(mk_user(2, 0, b)));
         chk("t1_tlast", DW'(m_axis_tlast), DW'(b == 2));
         chk("t1_s_tready", DW'(s_axis_tready), DW'(4'b0100));
      end
      cycle();
      chk("t1_end_grant", DW'(grant), DW'(0));
      chk("t1_end_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("t1_pkt_count", DW'(pkt_count), DW'(1));

      // All queues continuously valid, 2-beat packets: order 0,1,2,3,0,1,2,3.
      do_reset();
      for (int q = 0; q < N; q++) begin
         src_cnt[q] = 2;
         src_len[q] = 2;
      end
      drive();
      for (int k = 0; k < 8; k++) expect_pkt(k % 4, k / 4, 2, 2, 4'b1111);
      chk("t2_pkt_count", DW'(pkt_count), DW'(8));

      // Queue 1 owns the link while m_axis_tready toggles 1,0,0,1,1.
      pat   = '{1, 0, 0, 1, 1};
      pbeat = '{0, 1, 1, 1, 2};
      src_cnt[1] = 1;
      src_len[1] = 3;
      drive();
      begin
         int waits;
         waits = 0;
         while (grant == '0 && waits < 16) begin
            cycle();
            waits++;
         end
         chk("t3_wait", DW'(waits), DW'(2));
      end
      chk("t3_grant", DW'(grant), DW'(4'b0010));
      for (int i = 0; i < 5; i++) begin
         m_axis_tready = (pat[i] != 0);
         #1;
         chk("t3_s_tready", DW'(s_axis_tready), DW'((pat[i] != 0) ? 4'b0010 : 4'b0000));
         chk("t3_tvalid", DW'(m_axis_tvalid), DW'(1));
         chk("t3_tdata", m_axis_tdata, mk_data(1, 2, pbeat[i]));
         chk("t3_tlast", DW'(m_axis_tlast), DW'(pbeat[i] == 2));
         cycle();
      end
      m_axis_tready = 1'b1;
      chk("t3_end_grant", DW'(grant), DW'(0));
      chk("t3_pkt_count", DW'(pkt_count), DW'(9));

      // queue_en=1011 masks queue 2; clearing bit 1 mid-packet still completes it.
      do_reset();
      queue_en = 4'b1011;
      for (int q = 0; q < N; q++) begin
         src_cnt[q] = 1;
         src_len[q] = 3;
      end
      drive();
      expect_pkt(0, 0, 3, 2, 4'b1011);
      expect_pkt(1, 0, 3, 2, 4'b1001);
      expect_pkt(3, 0, 3, 2, 4'b1001);
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("t4_masked_grant", DW'(grant), DW'(0));
         chk("t4_masked_tvalid", DW'(m_axis_tvalid), DW'(0));
      end
      queue_en = 4'b1111;
      expect_pkt(2, 0, 3, 2, 4'b1111);
      chk("t4_pkt_count", DW'(pkt_count), DW'(4));

      // Reset on beat 2 of a 4-beat packet from queue 0.
      src_cnt[0] = 1;
      src_len[0] = 4;
      drive();
      begin
         int waits;
         waits = 0;
         while (grant == '0 && waits < 16) begin
            cycle();
            waits++;
         end
      end
      chk("t5_grant", DW'(grant), DW'(4'b0001));
      chk("t5_beat1", m_axis_tdata, mk_data(0, 1, 0));
      cycle();
      chk("t5_beat2", m_axis_tdata, mk_data(0, 1, 1));
      axi_resetn = 1'b0;
      #1;
      chk("t5_rst_grant", DW'(grant), DW'(0));
      chk("t5_rst_pkt_count", DW'(pkt_count), DW'(0));
      chk("t5_rst_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("t5_rst_tlast", DW'(m_axis_tlast), DW'(0));
      chk("t5_rst_tdata", m_axis_tdata, DW'(0));
      chk("t5_rst_tstrb", DW'(m_axis_tstrb), DW'(0));
      chk("t5_rst_tuser", DW'(m_axis_tuser), DW'(0));
      chk("t5_rst_s_tready", DW'(s_axis_tready), DW'(0));
      clear_srcs();
      drive();
      repeat (2) @(posedge clk);
      #3 axi_resetn = 1'b1;
      #1;
      chk("t5_post_pkt_count", DW'(pkt_count), DW'(0));
      for (int q = 0; q < N; q++) src_cnt[q] = 1;
      drive();
      for (int q = 0; q < N; q++) expect_pkt(q, 0, 1, 2, 4'b1111);
      chk("t5_pkt_count", DW'(pkt_count), DW'(4));

      // Counter wrap at 2^32.
      force dut.pkt_count = 32'hFFFF_FFFF;
      #1;
      release dut.pkt_count;
      #1;
      chk("t6_forced", DW'(pkt_count), DW'(32'hFFFF_FFFF));
      src_cnt[0] = 1;
      drive();
      expect_pkt(0, 1, 1, 2, 4'b1111);
      chk("t6_wrap", DW'(pkt_count), DW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
